// File: rtl/scan_mux.sv
// N-channel, W-bit registered multiplexer with manual-select and round-robin auto-scan modes.
// Every output is registered, so the channel data and channel tag arrive one cycle after
// the inputs that select them. In scan mode each channel is held for dwell+1 enabled cycles.
module scan_mux #(
  parameter int unsigned N_CH    = 8,
  parameter int unsigned W       = 1,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH*W-1:0]   in,
  input  logic                en,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [W-1:0]        out,
  output logic [SEL_W-1:0]    out_ch,
  output logic                out_valid,
  output logic                wrap
);

  typedef enum logic {
    StManual,
    StScan
  } state_e;

  localparam logic [SEL_W-1:0] LastCh = SEL_W'(N_CH - 1);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     cur_ch_q, cur_ch_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [W-1:0]         out_q, out_d;
  logic [SEL_W-1:0]     out_ch_q, out_ch_d;
  logic                 out_valid_q, out_valid_d;
  logic                 wrap_q, wrap_d;

  logic [W-1:0]         sel_data;
  logic [W-1:0]         scan_data;
  logic                 sel_ok;

  // Priority-free channel picker; an index with no matching channel yields zero.
  function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] data,
                                        input logic [SEL_W-1:0]  ch);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (ch == SEL_W'(k)) begin
        r = data[k*W +: W];
      end
    end
    return r;
  endfunction

  // Data for the manual selection and for the current scan channel.
  always_comb begin
    sel_data  = pick(in, sel);
    scan_data = pick(in, cur_ch_q);
    sel_ok    = (32'(sel) < N_CH);
  end

  // Next-state and next-output computation; en=0 holds everything but clears the strobes.
  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    dwell_cnt_d = dwell_cnt_q;
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = 1'b0;
    wrap_d      = 1'b0;

    if (en) begin
      unique case (state_q)
        StManual: begin
          if (mode) begin
            // Start-up bubble: restart the scan at channel 0, out/out_ch keep their values.
            state_d     = StScan;
            cur_ch_d    = '0;
            dwell_cnt_d = '0;
          end else begin
            out_d       = sel_ok ? sel_data : '0;
            out_ch_d    = sel;
            out_valid_d = sel_ok;
          end
        end
        StScan: begin
          if (!mode) begin
            // Leaving scan samples sel on this same edge, so there is no bubble.
            state_d     = StManual;
            out_d       = sel_ok ? sel_data : '0;
            out_ch_d    = sel;
            out_valid_d = sel_ok;
          end else begin
            out_d       = scan_data;
            out_ch_d    = cur_ch_q;
            out_valid_d = 1'b1;
            // >= so that lowering dwell below the running count forces an advance.
            if (dwell_cnt_q >= dwell) begin
              dwell_cnt_d = '0;
              if (cur_ch_q == LastCh) begin
                cur_ch_d = '0;
                wrap_d   = 1'b1;
              end else begin
                cur_ch_d = cur_ch_q + 1'b1;
              end
            end else begin
              dwell_cnt_d = dwell_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = StManual;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StManual;
      cur_ch_q    <= '0;
      dwell_cnt_q <= '0;
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      dwell_cnt_q <= dwell_cnt_d;
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised N-channel, W-bit registered multiplexer. It generalises the lab's 8:1 combinational selector.
- Adds a manual-select mode and an auto-scan mode. In auto-scan, the block steps round-robin through the channels and holds each one for a programmable dwell time.
- Feeds display and LED-scan stages that need a stable, registered channel sample with a channel tag.

Parameters:
- N_CH, 8, number of input channels (2..256).
- W, 1, bits per channel.
- SEL_W, 3, select/channel-index width. Must satisfy 2**SEL_W >= N_CH.
- DWELL_W, 8, width of the dwell-time field.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in  input  N_CH*W  packed channels. Channel k occupies bits [k*W+W-1 : k*W].
- en  input  1  global enable. 0 freezes all state.
- mode  input  1  0 = manual, 1 = auto-scan.
- sel  input  SEL_W  channel index used in manual mode.
- dwell  input  DWELL_W  in scan mode, each channel is held for dwell+1 sampled cycles.
- out  output  W  registered selected channel data.
- out_ch  output  SEL_W  index of the channel currently on out.
- out_valid  output  1  out/out_ch carry a legal sample.
- wrap  output  1  one-cycle pulse when scan advances from N_CH-1 to 0.

Behaviour:
- All outputs are registered. Latency is 1 cycle from the in/sel sample to out.
- Reset (rst=1 at a clk edge) overrides everything and takes effect at that edge, including mid-dwell or mid-scan.
  - Output values after reset: out=0, out_ch=0, out_valid=0, wrap=0.
  - Internal state after reset: state=MANUAL, cur_ch=0, dwell_cnt=0.
- wrap defaults to 0 on every edge unless it is set as described below.
- en=0: every register holds, except out_valid<=0 and wrap<=0. mode, sel and dwell are ignored.
- State machine (two states, evaluated only when en=1):
  - MANUAL, mode=0, sel<N_CH: out<=in[sel], out_ch<=sel, out_valid<=1.
  - MANUAL, mode=0, sel>=N_CH (only possible when N_CH is not a power of 2): out<=0, out_ch<=sel, out_valid<=0. The output is never driven to Z.
  - MANUAL, mode=1: next state SCAN; cur_ch<=0, dwell_cnt<=0, out_valid<=0 (start-up bubble, out/out_ch hold).
  - SCAN, mode=1: out<=in[cur_ch], out_ch<=cur_ch, out_valid<=1.
    - If dwell_cnt >= dwell: dwell_cnt<=0; cur_ch<=cur_ch+1, or 0 if cur_ch==N_CH-1; wrap<=1 only in that wrap case.
    - Otherwise: dwell_cnt<=dwell_cnt+1.
  - SCAN, mode=0: next state MANUAL. This edge already performs the manual sample of sel (no bubble).
- dwell is sampled live. Lowering dwell below the current dwell_cnt causes an advance on the next enabled edge (the >= compare). dwell=0 means a new channel on every enabled cycle.
- dwell_cnt and cur_ch never exceed DWELL_W and SEL_W bits. cur_ch never reaches N_CH.
- in changing mid-dwell is reflected on the next edge. The channel is held; the data is not latched.

Test Plan:
1. Reset, then manual mode, N_CH=8, W=4, in={8'h76,8'h54,8'h32,8'h10}, sel=5, en=1.
   - Required: one edge later, out=4'h5, out_ch=5, out_valid=1.
   - Then sel=7: next edge out=4'h7.
2. Scan with dwell=2 after mode 0->1.
   - Required: first edge gives out_valid=0.
   - Then out_ch=0,0,0,1,1,1,...,7,7,7,0.
   - wrap=1 exactly on the edge where out_ch shows the third 7, for one cycle only.
3. Scan with dwell=0.
   - Required: out_ch increments every cycle 0..7,0.
   - wrap pulses every 8 cycles.
   - en=0 for 3 cycles mid-scan: out_ch frozen, out_valid=0; resumes on the next channel without skipping.
4. N_CH=5, SEL_W=3, manual sel=6.
   - Required: out=0, out_valid=0.
   - Scan mode: out_ch cycles 0..4 only, wrap pulses on 4->0.
5. rst=1 asserted while scanning at out_ch=3 with dwell_cnt=1.
   - Required: next edge all outputs are 0 and state is MANUAL.
   - With mode still 1, the following edge gives a bubble (out_valid=0), then scan restarts at channel 0.
6. In scan, dwell changed 200->1 when dwell_cnt=50.
   - Required: the channel advances on the next edge, then dwells 2 cycles per channel.
